port_c_handshake: RTL
=====================

Name: port_c_handshake

Overview:
- Peripheral-side Mode 1 strobed handshake controller for one 8-bit 8255 port.
- Generates and consumes the port C control lines: STB/IBF/INTR for input, OBF/ACK/INTR for output.
- Latches peripheral data and presents an INTR/status nibble that the port C upper/lower CPU path reads.
- Sits between the external pins and the CPU bus logic. The control word decoder supplies mode, direction and INTE.

Parameters:
- DATA_W, 8, width of the port data path.
- SYNC_STAGES, 2, number of synchronizer flops on stb_n and ack_n (minimum 2).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; clears all state
- mode_en  input  1  1 = port is in Mode 1 handshake; 0 = handshake inactive
- dir  input  1  1 = input port, 0 = output port
- inte  input  1  interrupt enable bit (from port C bit set/reset)
- stb_n  input  1  peripheral strobe, active-low, asynchronous
- ack_n  input  1  peripheral acknowledge, active-low, asynchronous
- pin  input  DATA_W  peripheral data in
- cpu_rd  input  1  one-cycle pulse: CPU reads this port
- cpu_wr  input  1  one-cycle pulse: CPU writes this port
- cpu_wdata  input  DATA_W  CPU write data
- cpu_rdata  output  DATA_W  input latch contents
- pout  output  DATA_W  output latch to peripheral
- pout_oe  output  1  drive enable for pout
- ibf  output  1  input buffer full
- obf_n  output  1  output buffer full, active-low
- intr  output  1  interrupt request
- status  output  4  {intr, inte, buf_full, overrun}, where buf_full = ibf (dir=1) or ~obf_n (dir=0)

Behaviour:
Reset values:
- cpu_rdata=0, pout=0, pout_oe=0, ibf=0, obf_n=1, intr=0, overrun=0.
- Synchronizers preset to 1.

Synchronization and edge detection:
- stb_n and ack_n pass through SYNC_STAGES flops, then one edge-detect flop.
- An edge on a pin is acted on SYNC_STAGES+1 clocks after it arrives.
- pin is sampled on the same cycle the synchronized stb fall is detected. pin must be stable across the sync window.

Input FSM (mode_en=1, dir=1), states IN_EMPTY, IN_STROBED, IN_FULL:
- IN_EMPTY, stb fall: latch pin into cpu_rdata, ibf<=1, go to IN_STROBED.
- IN_STROBED, stb rise: go to IN_FULL; intr<=inte.
- IN_FULL, cpu_rd: intr<=0, ibf<=0, go to IN_EMPTY.
- cpu_rd in IN_STROBED: intr<=0 and ibf<=0; remain until stb rise, then go to IN_EMPTY with no intr.
- stb fall and cpu_rd in the same cycle: the read returns the old data; new data latched, ibf=1 (set wins).
- stb fall while ibf=1: behaviour per the optional feature.

Output FSM (mode_en=1, dir=0), states OUT_IDLE, OUT_FULL, OUT_ACK:
- pout_oe=1 for as long as the FSM is in output mode.
- cpu_wr in any state: pout<=cpu_wdata, obf_n<=0, intr<=0, go to OUT_FULL.
- OUT_FULL, ack fall: obf_n<=1, go to OUT_ACK.
- OUT_ACK, ack rise: intr<=inte, go to OUT_IDLE.
- cpu_wr and ack fall in the same cycle: the write wins (obf_n=0, state OUT_FULL).
- ack edges in OUT_IDLE are ignored.

INTE and mode changes:
- inte deasserted: intr<=0 on the next clock; intr is never set while inte=0.
- Any change of mode_en or dir: next clock goes to IN_EMPTY/OUT_IDLE with ibf=0, obf_n=1, intr=0, overrun=0. Latched data is retained.
- mode_en=0: pout_oe=0; all strobes and CPU pulses are ignored.

Reset asserted mid-handshake: all state returns to reset values on that clock, independent of pin levels.

Optional Feature:
- Macro: PORT_C_HS_OVERRUN_EN.
- Defined: an stb fall while ibf=1 is ignored and data is not latched. overrun<=1, sticky, cleared by cpu_rd, reset, or a mode/dir change.
- Undefined: an stb fall while ibf=1 overwrites cpu_rdata, and ibf stays 1. status[0] is tied to 0.

Test Plan:
- Reset, then mode_en=1, dir=1, inte=1, pin=8'hA5, pulse stb_n low for 5 clocks -> ibf=1 at 3 clocks after the fall, cpu_rdata=8'hA5, intr=1 at 3 clocks after the rise; cpu_rd -> ibf=0, intr=0 next clock.
- dir=0, inte=1, cpu_wr with 8'h3C -> pout=8'h3C, obf_n=0, pout_oe=1 next clock; ack_n low -> obf_n=1 after 3 clocks; ack_n high -> intr=1 after 3 clocks; next cpu_wr clears intr.
- Input strobe with inte=0 -> ibf=1, intr stays 0; then set inte=1 -> intr remains 0 (set only on the strobe-rise event).
- Second strobe with pin=8'h5A while ibf=1 -> without PORT_C_HS_OVERRUN_EN: cpu_rdata=8'h5A, status[0]=0; with it: cpu_rdata=8'hA5, status[0]=1, cleared by cpu_rd.
- Same-cycle stb fall and cpu_rd -> ibf=1 with new data latched; same-cycle cpu_wr and ack fall -> obf_n=0.
- Assert reset in OUT_FULL and in IN_STROBED -> all outputs return to reset values next clock; also toggle dir mid-handshake -> ibf=0, obf_n=1, intr=0.

Source files
------------

// File: rtl/port_c_handshake.sv
// ---------------------------------------------------------------------------
// port_c_handshake
//   Peripheral-side Mode 1 strobed handshake for one 8255-style port.
//   Input direction:  STB# strobes pin data into cpu_rdata, raising IBF/INTR.
//   Output direction: CPU writes drive pout, OBF# falls, ACK# completes it.
//
// Optional feature macro: PORT_C_HS_OVERRUN_EN
//   defined   : a strobe while ibf=1 is dropped and sets sticky overrun
//   undefined : a strobe while ibf=1 overwrites cpu_rdata; overrun is 0
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   mode_en, dir, inte  from control-word decoder (dir: 1=input, 0=output)
//   stb_n, ack_n        asynchronous active-low peripheral handshake pins
//   pin                 peripheral data in
//   cpu_rd, cpu_wr      one-cycle CPU access pulses; cpu_wdata write data
//   cpu_rdata           input latch
//   pout, pout_oe       output latch and its drive enable
//   ibf, obf_n, intr    handshake status lines
//   status              {intr, inte, buf_full, overrun}
// ---------------------------------------------------------------------------
module port_c_handshake #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode_en,
  input  logic              dir,
  input  logic              inte,
  input  logic              stb_n,
  input  logic              ack_n,
  input  logic [DATA_W-1:0] pin,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [DATA_W-1:0] pout,
  output logic              pout_oe,
  output logic              ibf,
  output logic              obf_n,
  output logic              intr,
  output logic [3:0]        status
);

`ifdef PORT_C_HS_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IN_EMPTY, IN_STROBED, IN_FULL, OUT_IDLE, OUT_FULL, OUT_ACK
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] stb_sync_p0, ack_sync_p0;
  logic                   stb_prev_p1, ack_prev_p1;
  logic                   stb_s, ack_s;
  logic                   stb_fall, stb_rise, ack_fall, ack_rise;
  logic                   mode_q, dir_q;
  logic                   mode_chg, in_act, out_act;
  logic                   overrun;

  // Stage p0: synchronizer chain, preset high (pins idle high)
  // Stage p1: edge-detect flop on the synchronized level
  always_ff @(posedge clk) begin
    if (reset) begin
      stb_sync_p0 <= '1;
      ack_sync_p0 <= '1;
      stb_prev_p1 <= 1'b1;
      ack_prev_p1 <= 1'b1;
    end else begin
      stb_sync_p0 <= {stb_sync_p0[SYNC_STAGES-2:0], stb_n};
      ack_sync_p0 <= {ack_sync_p0[SYNC_STAGES-2:0], ack_n};
      stb_prev_p1 <= stb_s;
      ack_prev_p1 <= ack_s;
    end
  end

  assign stb_s    = stb_sync_p0[SYNC_STAGES-1];
  assign ack_s    = ack_sync_p0[SYNC_STAGES-1];
  assign stb_fall = stb_prev_p1 & ~stb_s;
  assign stb_rise = ~stb_prev_p1 & stb_s;
  assign ack_fall = ack_prev_p1 & ~ack_s;
  assign ack_rise = ~ack_prev_p1 & ack_s;

  // A mode/dir change pre-empts everything for one clock and re-arms the FSM.
  assign mode_chg = (mode_en != mode_q) || (dir != dir_q);
  assign in_act   = mode_en & dir & ~mode_chg;
  assign out_act  = mode_en & ~dir & ~mode_chg;

  // Stage p2: handshake FSM and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IN_EMPTY;
      ibf       <= 1'b0;
      obf_n     <= 1'b1;
      intr      <= 1'b0;
      overrun   <= 1'b0;
      cpu_rdata <= '0;
      pout      <= '0;
      pout_oe   <= 1'b0;
      mode_q    <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      mode_q  <= mode_en;
      dir_q   <= dir;
      pout_oe <= mode_en & ~dir;
      if (mode_chg) begin
        state   <= dir ? IN_EMPTY : OUT_IDLE;
        ibf     <= 1'b0;
        obf_n   <= 1'b1;
        intr    <= 1'b0;
        overrun <= 1'b0;
      end else if (in_act) begin
        // A read frees the buffer; a same-cycle strobe below re-sets ibf.
        if (cpu_rd) begin
          ibf     <= 1'b0;
          intr    <= 1'b0;
          overrun <= 1'b0;
        end
        case (state)
          IN_EMPTY: begin
            if (stb_fall) begin
              cpu_rdata <= pin;
              ibf       <= 1'b1;
              state     <= IN_STROBED;
            end
          end
          IN_STROBED: begin
            // ibf already cleared means the CPU read early: no interrupt.
            if (stb_rise) begin
              if (ibf && !cpu_rd) begin
                state <= IN_FULL;
                intr  <= inte;
              end else begin
                state <= IN_EMPTY;
              end
            end
          end
          IN_FULL: begin
            if (stb_fall) begin
              if (OVR_EN && !cpu_rd) begin
                overrun <= 1'b1;
              end else begin
                cpu_rdata <= pin;
                ibf       <= 1'b1;
                state     <= IN_STROBED;
              end
            end else if (cpu_rd) begin
              state <= IN_EMPTY;
            end
          end
          default: state <= IN_EMPTY;
        endcase
      end else if (out_act) begin
        if (cpu_wr) begin
          pout  <= cpu_wdata;
          obf_n <= 1'b0;
          intr  <= 1'b0;
          state <= OUT_FULL;
        end else begin
          case (state)
            OUT_IDLE: ;
            OUT_FULL: begin
              if (ack_fall) begin
                obf_n <= 1'b1;
                state <= OUT_ACK;
              end
            end
            OUT_ACK: begin
              if (ack_rise) begin
                intr  <= inte;
                state <= OUT_IDLE;
              end
            end
            default: state <= OUT_IDLE;
          endcase
        end
      end
      // Interrupts are masked immediately by a cleared enable.
      if (!inte) intr <= 1'b0;
    end
  end

  assign status = {intr, inte, (dir ? ibf : ~obf_n), overrun};

endmodule
